mcdf_arbiter_n: RTL

MCDF_ARBITER_N -- requirements
Module: mcdf_arbiter_n

---
 rtl/mcdf_arb_pkg.sv | 13 +
 rtl/mcdf_rr_pick.sv | 59 +++++
 rtl/mcdf_arbiter_n.sv | 95 +++++++++
 3 files changed

// File: rtl/mcdf_arb_pkg.sv
// mcdf_arb_pkg: shared types for the MCDF channel arbiter.
// Holds the FSM state encoding and the default priority width.
package mcdf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } arb_state_e;

  localparam int PRIO_W_DEF = 2;

endpackage

// File: rtl/mcdf_rr_pick.sv
// mcdf_rr_pick: combinational winner select for the MCDF arbiter.
// Lowest priority value wins; ties go fixed-low or round-robin.
module mcdf_rr_pick
  import mcdf_arb_pkg::*;
#(
  parameter  int NUM_CH = 3,
  parameter  int PRIO_W = PRIO_W_DEF,
  localparam int ID_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]        elig,
  input  logic [NUM_CH*PRIO_W-1:0] prios,
  input  logic                     rr_mode,
  input  logic [ID_W-1:0]          last_win,
  output logic [ID_W-1:0]          win_id,
  output logic                     any_elig
);

  logic [PRIO_W-1:0] best;
  logic [NUM_CH-1:0] tie;
  logic              found;
  int                j;

  // best (numerically lowest) priority among eligible channels
  always_comb begin
    best = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (elig[i] && (prios[i*PRIO_W +: PRIO_W] < best))
        best = prios[i*PRIO_W +: PRIO_W];
    end
  end

  // eligible channels sitting at the best priority
  always_comb begin
    tie = '0;
    for (int i = 0; i < NUM_CH; i++)
      tie[i] = elig[i] &&
               (prios[i*PRIO_W +: PRIO_W] == best);
  end

  // first tied channel: from 0, or from last_win+1 wrapping
  always_comb begin
    win_id = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rr_mode)
        j = (int'(last_win) + k + 1) % NUM_CH;
      else
        j = k;
      if (!found && tie[j]) begin
        found  = 1'b1;
        win_id = ID_W'(j);
      end
    end
  end

  assign any_elig = |elig;

endmodule

// File: rtl/mcdf_arbiter_n.sv
// mcdf_arbiter_n: N-channel priority arbiter feeding the formatter.
// Registers the winner ID and issues a one-cycle ack/strobe.
module mcdf_arbiter_n
  import mcdf_arb_pkg::*;
#(
  parameter  int NUM_CH = 3,
  parameter  int PRIO_W = PRIO_W_DEF,
  localparam int ID_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        slv_reqs,
  input  logic [NUM_CH*PRIO_W-1:0] slv_prios,
  input  logic [NUM_CH-1:0]        chnl_en,
  input  logic                     rr_mode,
  input  logic                     f2a_id_req,
  output logic [NUM_CH-1:0]        a2s_acks,
  output logic [ID_W-1:0]          a2f_id,
  output logic                     a2f_id_vld
);

  arb_state_e        state;
  arb_state_e        nxt;
  logic              take;
  logic [NUM_CH-1:0] elig;
  logic              any_elig;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   last_win;

  assign elig = slv_reqs & chnl_en;

  mcdf_rr_pick #(
    .NUM_CH (NUM_CH),
    .PRIO_W (PRIO_W)
  ) u_pick (
    .elig     (elig),
    .prios    (slv_prios),
    .rr_mode  (rr_mode),
    .last_win (last_win),
    .win_id   (win_id),
    .any_elig (any_elig)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next state; take marks the edge that latches a winner
  always_comb begin
    nxt  = state;
    take = 1'b0;
    unique case (state)
      IDLE: begin
        if (f2a_id_req) begin
          if (any_elig) begin
            nxt  = GRANT;
            take = 1'b1;
          end else begin
            nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (any_elig) begin
          nxt  = GRANT;
          take = 1'b1;
        end else if (!f2a_id_req) begin
          nxt = IDLE;
        end
      end
      GRANT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // winner capture, strobe and one-hot ack for the GRANT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a2f_id     <= '0;
      a2f_id_vld <= 1'b0;
      a2s_acks   <= '0;
      last_win   <= ID_W'(NUM_CH - 1);
    end else begin
      a2f_id_vld <= take;
      a2s_acks   <= take ? (NUM_CH'(1) << win_id) : '0;
      if (take) begin
        a2f_id   <= win_id;
        last_win <= win_id;
      end
    end
  end

endmodule
